// File: rtl/memtest_hex_if.sv
// Capture/display bundle between the memory-test sequencer, the hex display
// block and whoever observes it (board pins or a bench).
interface memtest_hex_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic [15:0]          q_a;
  logic [15:0]          q_b;
  logic                 selectout;
  logic                 capture;
  logic                 freeze;
  logic [6:0]           seg;
  logic [3:0]           an;
  logic [15:0]          word;
  logic [CNT_WIDTH-1:0] cap_count;

  modport master (
    output q_a, q_b, selectout, capture, freeze,
    input  seg, an, word, cap_count
  );

  modport slave (
    input  q_a, q_b, selectout, capture, freeze,
    output seg, an, word, cap_count
  );
endinterface

// File: rtl/memtest_hex_display.sv
// Captures the selected RAM read word and scans it onto a 4-digit active-low
// 7-segment display. Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module memtest_hex_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  memtest_hex_if.slave  bus
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0]        ref_q, ref_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          word_q, word_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           nib;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the most significant nonzero nibble; 0 when the word is zero.
  function automatic logic [1:0] msd_index(input logic [15:0] w);
    if (w[15:12] != 4'h0)     msd_index = 2'd3;
    else if (w[11:8] != 4'h0) msd_index = 2'd2;
    else if (w[7:4] != 4'h0)  msd_index = 2'd1;
    else                      msd_index = 2'd0;
  endfunction
`endif

  always_comb begin
    ref_d  = ref_q + 1'b1;
    idx_d  = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end

    word_d = word_q;
    cnt_d  = cnt_q;
    if (bus.capture && !bus.freeze) begin
      word_d = bus.selectout ? bus.q_b : bus.q_a;
      cnt_d  = cnt_q + 1'b1;
    end

    nib   = 4'(word_q >> {idx_q, 2'b00});
    an_d  = ~(4'b0001 << idx_q);
`ifdef LEADING_ZERO_BLANK_EN
    seg_d = (idx_q > msd_index(word_q)) ? 7'h7F : hex_glyph(nib);
`else
    seg_d = hex_glyph(nib);
`endif
  end

  // Output registers follow the current index by one cycle so anode and glyph switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q  <= '0;
      idx_q  <= 2'd0;
      word_q <= 16'h0000;
      cnt_q  <= '0;
      an_q   <= 4'b1110;
      seg_q  <= 7'h40;
    end else begin
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.word      = word_q;
  assign bus.cap_count = cnt_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_memtest_hex_display.sv
// Scoreboard bench for memtest_hex_display: capture results and scan digits are
// queued when stimulus is driven and compared as the DUT produces them.
module tb_memtest_hex_display;

  localparam int unsigned DIV = 4;

  typedef struct { logic [15:0] w; logic [7:0] c; } cap_t;
  typedef struct { logic [3:0] an; logic [6:0] seg; } dig_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] m_word;
  logic [7:0]  m_cnt;
  cap_t cap_q[$];
  dig_t dig_q[$];

  memtest_hex_if #(.CNT_WIDTH(8)) bus ();

  memtest_hex_display #(.REFRESH_DIV(DIV), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] w, input int d);
    logic [15:0] upper;
    upper = w >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0) return 7'h7F;
`endif
    return ref_glyph(upper[3:0]);
  endfunction

  function automatic int an_to_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Drive one capture strobe on a negedge, check the result one clock later.
  task automatic do_capture(input logic [15:0] qa, input logic [15:0] qb,
                            input logic sel, input logic frz);
    cap_t e;
    bus.q_a = qa; bus.q_b = qb; bus.selectout = sel; bus.freeze = frz;
    bus.capture = 1'b1;
    if (!frz) begin
      m_word = sel ? qb : qa;
      m_cnt  = m_cnt + 8'd1;
    end
    e.w = m_word; e.c = m_cnt;
    cap_q.push_back(e);
    @(negedge clk);
    bus.capture = 1'b0;
    e = cap_q.pop_front();
    check_eq("word", bus.word, e.w);
    check_eq("cap_count", bus.cap_count, e.c);
  endtask

  // Follow one full scan of four digits, checking anode, glyph and dwell.
  task automatic scan_check(input string tag, input logic [15:0] w);
    dig_t d;
    logic [3:0] prev;
    int cur, n;
    bit changed;
    @(negedge clk);
    prev = bus.an;
    cur = an_to_idx(prev);
    check_eq({tag, "_an_onehot"}, (cur >= 0), 1);
    if (cur < 0) cur = 0;
    for (int k = 1; k <= 4; k++) begin
      d.an  = ~(4'b0001 << ((cur + k) % 4));
      d.seg = exp_seg(w, (cur + k) % 4);
      dig_q.push_back(d);
    end
    for (int k = 0; k < 4; k++) begin
      changed = 1'b0;
      n = 0;
      while (!changed && n < 3 * DIV) begin
        @(negedge clk);
        n++;
        if (bus.an !== prev) changed = 1'b1;
      end
      check_eq({tag, "_scan_wait"}, changed, 1);
      d = dig_q.pop_front();
      check_eq({tag, "_an"}, bus.an, d.an);
      check_eq({tag, "_seg"}, bus.seg, d.seg);
      if (k > 0) check_eq({tag, "_dwell"}, n, DIV);
      prev = bus.an;
    end
  endtask

  initial begin
    bit seen;
    int n;
    rst = 1'b1;
    bus.q_a = '0; bus.q_b = '0; bus.selectout = 1'b0;
    bus.capture = 1'b0; bus.freeze = 1'b0;
    m_word = '0; m_cnt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_an", bus.an, 4'b1110);
    check_eq("rst_seg", bus.seg, 7'h40);
    check_eq("rst_word", bus.word, 16'h0000);
    check_eq("rst_cnt", bus.cap_count, 8'd0);

    do_capture(16'h1234, 16'h5555, 1'b0, 1'b0);
    scan_check("capA", 16'h1234);

    do_capture(16'h7777, 16'hBEEF, 1'b1, 1'b0);
    scan_check("capB", 16'hBEEF);

    do_capture(16'h00FF, 16'h00FF, 1'b0, 1'b1);
    scan_check("freeze", 16'hBEEF);
    bus.freeze = 1'b0;

    do_capture(16'h0040, 16'h0000, 1'b0, 1'b0);
    scan_check("w0040", 16'h0040);
    do_capture(16'h0000, 16'h1111, 1'b0, 1'b0);
    scan_check("w0000", 16'h0000);
    do_capture(16'hA5C3, 16'h0000, 1'b0, 1'b0);
    scan_check("wA5C3", 16'hA5C3);

    // Run the counter through its wrap back to zero.
    while (m_cnt != 8'd255)
      do_capture(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    do_capture(16'h0DEF, 16'h0000, 1'b0, 1'b0);
    check_eq("wrap_cnt", bus.cap_count, 8'd0);
    scan_check("w0DEF", 16'h0DEF);

    // Reset beats a simultaneous capture.
    bus.q_a = 16'hABCD; bus.selectout = 1'b0; bus.capture = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.capture = 1'b0;
    m_word = '0; m_cnt = '0;
    check_eq("prio_word", bus.word, 16'h0000);
    check_eq("prio_cnt", bus.cap_count, 8'd0);
    check_eq("prio_an", bus.an, 4'b1110);

    // Reset in the middle of the scan, while digit 3 is lit.
    do_capture(16'h9876, 16'h0000, 1'b0, 1'b0);
    seen = 1'b0; n = 0;
    while (!seen && n < 8 * DIV) begin
      @(negedge clk);
      n++;
      if (bus.an === 4'b0111) seen = 1'b1;
    end
    check_eq("mid_wait", seen, 1);
    check_eq("mid_seg3", bus.seg, 7'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_an", bus.an, 4'b1110);
    check_eq("mid_seg", bus.seg, 7'h40);
    scan_check("post_rst", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
